// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared definitions for the Game of Life generation scheduler:
//               default grid geometry, scheduler state encoding and the
//               colour constants the sprite renderer uses for cell display.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    // Default grid geometry (rows are sprite rows, row word bit c = column c)
    localparam int ROWS = 15;
    localparam int COLS = 20;
    localparam int RW   = 4;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        RUN     = 2'd2,
        WAIT_VB = 2'd3
    } life_state_e;

    // 8-bit RRRGGGBB colours shared with the renderer
    localparam logic [7:0] COLOUR_ALIVE = 8'b000_111_00;
    localparam logic [7:0] COLOUR_DEAD  = 8'b000_000_00;

endpackage
`default_nettype wire

// File: rtl/life_row_next.sv
`default_nettype none
// ============================================================================
// Module      : life_row_next
// Description : Combinational next-generation calculator for one grid row.
//               Counts the eight neighbours of every cell from a three-row
//               window and applies the Life rule.
// Ports       : prev     - row above the row being updated
//               cur      - row being updated
//               nxt      - row below the row being updated
//               next_row - next-generation value of cur
// Revision    : 1.0 - initial release
// ============================================================================
module life_row_next #(
    parameter int COLS = life_pkg::COLS,
    parameter int WRAP = 0
) (
    input  logic [COLS-1:0] prev,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] nxt,
    output logic [COLS-1:0] next_row
);

    // Rows extended by one column on each side: bit 0 holds column -1 and
    // bit COLS+1 holds column COLS, so cell c sees ext bits c, c+1, c+2.
    logic [COLS+1:0] w_prev_ext;
    logic [COLS+1:0] w_cur_ext;
    logic [COLS+1:0] w_nxt_ext;

    if (WRAP != 0) begin : g_wrap
        assign w_prev_ext = {prev[0], prev, prev[COLS-1]};
        assign w_cur_ext  = {cur[0],  cur,  cur[COLS-1]};
        assign w_nxt_ext  = {nxt[0],  nxt,  nxt[COLS-1]};
    end else begin : g_dead
        assign w_prev_ext = {1'b0, prev, 1'b0};
        assign w_cur_ext  = {1'b0, cur,  1'b0};
        assign w_nxt_ext  = {1'b0, nxt,  1'b0};
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        logic [3:0] w_n;

        assign w_n = 4'(w_prev_ext[c]) + 4'(w_prev_ext[c+1]) + 4'(w_prev_ext[c+2])
                   + 4'(w_cur_ext[c])                        + 4'(w_cur_ext[c+2])
                   + 4'(w_nxt_ext[c])  + 4'(w_nxt_ext[c+1])  + 4'(w_nxt_ext[c+2]);

        assign next_row[c] = (w_n == 4'd3) | (w_cur_ext[c+1] & (w_n == 4'd2));
    end

endmodule
`default_nettype wire

// File: rtl/life_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : life_gen_scheduler
// Description : Double-buffered Game of Life grid with a one-row-per-clock
//               generation engine. The engine reads the front buffer through
//               a three-row sliding window and writes the back buffer; the
//               buffers swap only during vertical blanking.
// Ports       : clk, rst_n          - clock, async active-low reset
//               step_req            - request one generation (IDLE only)
//               vblank              - vertical blanking indicator
//               load_en/row/data    - front-buffer row write (IDLE only)
//               disp_row/disp_data  - registered front-buffer read port
//               busy                - engine active (PRIME..swap)
//               done                - pulse the cycle after a swap
//               gen_count           - completed generations (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module life_gen_scheduler #(
    parameter int ROWS = life_pkg::ROWS,
    parameter int COLS = life_pkg::COLS,
    parameter int RW   = life_pkg::RW,
    parameter int WRAP = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step_req,
    input  logic            vblank,
    input  logic            load_en,
    input  logic [RW-1:0]   load_row,
    input  logic [COLS-1:0] load_data,
    input  logic [RW-1:0]   disp_row,
    output logic [COLS-1:0] disp_data,
    output logic            busy,
    output logic            done,
    output logic [15:0]     gen_count
);
    import life_pkg::*;

    life_state_e     state_q, state_d;
    logic            front_sel_q, front_sel_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] prev_q, prev_d;
    logic [COLS-1:0] cur_q, cur_d;
    logic [COLS-1:0] nxt_q, nxt_d;
    logic [COLS-1:0] buf0_q [ROWS];
    logic [COLS-1:0] buf0_d [ROWS];
    logic [COLS-1:0] buf1_q [ROWS];
    logic [COLS-1:0] buf1_d [ROWS];
    logic [COLS-1:0] disp_q, disp_d;
    logic            done_q, done_d;
    logic [15:0]     gen_q, gen_d;

    logic [COLS-1:0] w_front [ROWS];
    logic [COLS-1:0] w_life_row;
    logic [RW:0]     w_fetch_idx;
    logic [COLS-1:0] w_fetch_row;
    logic            w_disp_ok;
    logic            w_load_ok;
    logic            w_last_row;

    // Front buffer view; front_sel=0 means buf0 is displayed
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            w_front[i] = front_sel_q ? buf1_q[i] : buf0_q[i];
        end
    end

    assign w_disp_ok  = 32'(disp_row) < ROWS;
    assign w_load_ok  = 32'(load_row) < ROWS;
    assign w_last_row = 32'(row_q) == (ROWS - 1);

    // Row entering the window two rows ahead of the one being written;
    // past the bottom edge it wraps to the top or reads as dead.
    assign w_fetch_idx = {1'b0, row_q} + (RW+1)'(2);

    always_comb begin
        w_fetch_row = '0;
        if (32'(w_fetch_idx) < ROWS) begin
            w_fetch_row = w_front[w_fetch_idx[RW-1:0]];
        end else if (WRAP != 0) begin
            w_fetch_row = w_front[RW'(w_fetch_idx - (RW+1)'(ROWS))];
        end
    end

    life_row_next #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row_next (
        .prev     (prev_q),
        .cur      (cur_q),
        .nxt      (nxt_q),
        .next_row (w_life_row)
    );

    // Next-state / datapath
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        row_d       = row_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        gen_d       = gen_q;
        done_d      = 1'b0;
        disp_d      = w_disp_ok ? w_front[disp_row] : '0;

        unique case (state_q)
            IDLE: begin
                // A load in the same cycle as a step request wins.
                if (load_en) begin
                    if (w_load_ok) begin
                        if (front_sel_q) buf1_d[load_row] = load_data;
                        else             buf0_d[load_row] = load_data;
                    end
                end else if (step_req) begin
                    state_d = PRIME;
                end
            end

            PRIME: begin
                prev_d  = (WRAP != 0) ? w_front[ROWS-1] : '0;
                cur_d   = w_front[0];
                nxt_d   = w_front[1];
                row_d   = '0;
                state_d = RUN;
            end

            RUN: begin
                if (front_sel_q) buf0_d[row_q] = w_life_row;
                else             buf1_d[row_q] = w_life_row;
                prev_d = cur_q;
                cur_d  = nxt_q;
                nxt_d  = w_fetch_row;
                row_d  = row_q + RW'(1);
                if (w_last_row) begin
                    state_d = WAIT_VB;
                end
            end

            WAIT_VB: begin
                if (vblank) begin
                    front_sel_d = ~front_sel_q;
                    gen_d       = gen_q + 16'd1;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            row_q       <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            disp_q      <= '0;
            done_q      <= 1'b0;
            gen_q       <= '0;
            for (int i = 0; i < ROWS; i++) begin
                buf0_q[i] <= '0;
                buf1_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            row_q       <= row_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            disp_q      <= disp_d;
            done_q      <= done_d;
            gen_q       <= gen_d;
            for (int i = 0; i < ROWS; i++) begin
                buf0_q[i] <= buf0_d[i];
                buf1_q[i] <= buf1_d[i];
            end
        end
    end

    assign disp_data = disp_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign gen_count = gen_q;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_gen_scheduler
// Description : Self-checking bench for life_gen_scheduler. Two instances
//               (dead edges and toroidal) share all inputs; a grid-level
//               model predicts every output each cycle, and directed
//               patterns (blinker, block, gliders) pin known results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_gen_scheduler;

    localparam int NR  = 15;
    localparam int NC  = 20;
    localparam int LAT = NR + 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        step_req, vblank, load_en;
    logic [3:0]  load_row, disp_row;
    logic [19:0] load_data;

    logic [19:0] disp0, disp1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] gen0, gen1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    life_gen_scheduler #(.ROWS(NR), .COLS(NC), .RW(4), .WRAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .step_req(step_req), .vblank(vblank),
        .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .disp_row(disp_row), .disp_data(disp0), .busy(busy0), .done(done0),
        .gen_count(gen0)
    );

    life_gen_scheduler #(.ROWS(NR), .COLS(NC), .RW(4), .WRAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .step_req(step_req), .vblank(vblank),
        .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .disp_row(disp_row), .disp_data(disp1), .busy(busy1), .done(done1),
        .gen_count(gen1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- grid-level model (index 0: dead edges, 1: torus) ----
    logic [19:0] m_grid [2][NR];
    logic [19:0] m_pend [2][NR];
    logic [19:0] m_disp [2];
    int          m_ph;      // 0 idle, else cycles since the step was accepted
    logic        m_done;
    logic [15:0] m_gen;

    function automatic int alive(input int w, input int r, input int c);
        int rr, cc;
        if (w == 1) begin
            rr = (r + NR) % NR;
            cc = (c + NC) % NC;
        end else begin
            if (r < 0 || r >= NR || c < 0 || c >= NC) return 0;
            rr = r;
            cc = c;
        end
        return m_grid[w][rr][cc] ? 1 : 0;
    endfunction

    task automatic model_next_gen();
        for (int w = 0; w < 2; w++)
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) begin
                    int n;
                    n = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if (dr != 0 || dc != 0) n += alive(w, r + dr, c + dc);
                    m_pend[w][r][c] = (n == 3) || (alive(w, r, c) == 1 && n == 2);
                end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 2; w++) begin
                m_disp[w] = '0;
                for (int r = 0; r < NR; r++) m_grid[w][r] = '0;
            end
            m_ph   = 0;
            m_done = 1'b0;
            m_gen  = '0;
        end else begin
            for (int w = 0; w < 2; w++)
                m_disp[w] = (int'(disp_row) < NR) ? m_grid[w][disp_row] : 20'h0;
            m_done = 1'b0;
            if (m_ph == 0) begin
                if (load_en) begin
                    if (int'(load_row) < NR)
                        for (int w = 0; w < 2; w++) m_grid[w][load_row] = load_data;
                end else if (step_req) begin
                    model_next_gen();
                    m_ph = 1;
                end
            end else if (m_ph < NR + 2) begin
                m_ph++;
            end else if (vblank) begin
                for (int w = 0; w < 2; w++)
                    for (int r = 0; r < NR; r++) m_grid[w][r] = m_pend[w][r];
                m_gen++;
                m_ph   = 0;
                m_done = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("disp0", disp0, m_disp[0]);
            check("disp1", disp1, m_disp[1]);
            check("busy0", busy0, m_ph != 0);
            check("busy1", busy1, m_ph != 0);
            check("done0", done0, m_done);
            check("done1", done1, m_done);
            check("gen0",  gen0,  m_gen);
            check("gen1",  gen1,  m_gen);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ---------------
    task automatic do_reset();
        rst_n    = 1'b0;
        load_en  = 1'b0;
        step_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int r, input logic [19:0] d);
        load_en   = 1'b1;
        load_row  = r[3:0];
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic check_row(input string nm, input int inst, input int r, input logic [19:0] exp);
        disp_row = r[3:0];
        @(negedge clk);
        @(negedge clk);
        check(nm, (inst == 0) ? disp0 : disp1, exp);
    endtask

    // Waits for done (counting from the cycle step_req was raised) with a bound.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            step_req = 1'b0;
            k++;
        end while (done0 !== 1'b1 && k < 300);
        if (done0 !== 1'b1) check("done_timeout", {31'b0, done0}, 32'd1);
    endtask

    task automatic do_step(input bit chk_lat);
        int k;
        step_req = 1'b1;
        wait_done(k);
        if (chk_lat) check("step_latency", k, LAT);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        step_req = 0; vblank = 1; load_en = 0;
        load_row = 0; load_data = 0; disp_row = 0;
        @(negedge clk);
        do_reset();

        // Reset state: every row reads zero, engine idle
        for (int r = 0; r < 16; r++) begin
            check_row("rst_row_d0", 0, r, 20'h0);
            check("rst_row_d1", disp1, 20'h0);
        end
        check("rst_busy", busy0, 1'b0);
        check("rst_gen", gen0, 16'h0);

        // Blinker oscillates with period 2
        load(7, 20'h00700);
        do_step(1'b1);
        check_row("blink_r6", 0, 6, 20'h00200);
        check_row("blink_r7", 1, 7, 20'h00200);
        check_row("blink_r8", 0, 8, 20'h00200);
        do_step(1'b1);
        check_row("blink_back_r7", 0, 7, 20'h00700);
        check_row("blink_back_r6", 1, 6, 20'h00000);

        // Still-life block is unchanged after three generations
        do_reset();
        load(3, 20'h0000C);
        load(4, 20'h0000C);
        for (int i = 0; i < 3; i++) do_step(1'b1);
        check_row("block_r3", 0, 3, 20'h0000C);
        check_row("block_r4", 1, 4, 20'h0000C);
        check("block_gen", gen0, 16'd3);

        // Swap waits for vblank; old pattern stays visible meanwhile
        do_reset();
        load(7, 20'h00700);
        vblank   = 1'b0;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (39) @(negedge clk);
        check("hold_busy", busy0, 1'b1);
        check("hold_done", done0, 1'b0);
        check_row("hold_old_r7", 0, 7, 20'h00700);
        vblank = 1'b1;
        @(negedge clk);
        check("vb_done", done0, 1'b1);
        check("vb_busy", busy0, 1'b0);
        check("vb_gen", gen0, 16'd1);
        check_row("vb_new_r6", 0, 6, 20'h00200);

        // Torus: glider at top-left moves by (+1,+1) after four generations
        do_reset();
        load(0, 20'h00002);
        load(1, 20'h00004);
        load(2, 20'h00007);
        for (int i = 0; i < 4; i++) do_step(1'b0);
        check_row("glider_w_r0", 1, 0, 20'h00000);
        check_row("glider_w_r1", 1, 1, 20'h00004);
        check_row("glider_w_r2", 1, 2, 20'h00008);
        check_row("glider_w_r3", 1, 3, 20'h0000E);

        // Dead edges: glider at bottom-right collapses into a block
        do_reset();
        load(12, 20'h40000);
        load(13, 20'h80000);
        load(14, 20'hE0000);
        for (int i = 0; i < 4; i++) do_step(1'b0);
        check_row("glider_d_r12", 0, 12, 20'h00000);
        check_row("glider_d_r13", 0, 13, 20'hC0000);
        check_row("glider_d_r14", 0, 14, 20'hC0000);

        // Load and step pulses during RUN are ignored; steps are not queued
        do_reset();
        load(7, 20'h00700);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (4) @(negedge clk);
        load_en = 1'b1; load_row = 4'd0; load_data = 20'hFFFFF; step_req = 1'b1;
        @(negedge clk);
        load_en = 1'b0; step_req = 1'b0;
        wait_done(k);
        repeat (25) @(negedge clk);
        check("ign_gen", gen0, 16'd1);
        check("ign_busy", busy0, 1'b0);
        check_row("ign_r0", 0, 0, 20'h00000);
        check_row("ign_r7", 1, 7, 20'h00200);

        // Reset in the middle of RUN clears everything at once
        disp_row = 4'd7;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_disp", disp0, 20'h00200);
        check("pre_rst_busy", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_disp0", disp0, 20'h0);
        check("mid_rst_disp1", disp1, 20'h0);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_done", done0, 1'b0);
        check("mid_rst_gen", gen0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_row("post_rst_r7", 0, 7, 20'h00000);
        check_row("post_rst_r8", 1, 8, 20'h00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
